mult_add_pipe: RTL and testbench

Parametrised, pipelined, signed multiply-add/subtract with a per-channel accumulator bank and output saturation. It is the next generation of the fixed-width combinational 16x16+32 multiply-add used in the servo and scaling datapaths. It adds configurable widths, a registered valid pipeline, accumulate mode and overflow clamping. It sits between the parameter/DDS scaling logic and the servo output registers.

---
 rtl/mult_add_pipe_pkg.sv | 38 +++
 rtl/mult_add_pipe_sat_round.sv | 23 ++
 rtl/mult_add_pipe.sv | 142 ++++++++++++++
 tb/tb_mult_add_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_add_pipe_pkg.sv
// Shared definitions for the pipelined multiply-add: op encodings, width helper, clamp function.
package mult_add_pipe_pkg;

    // {accumulate, subtract}
    typedef enum logic [1:0] {
        ADD     = 2'b00,
        SUB     = 2'b01,
        ACC_ADD = 2'b10,
        ACC_SUB = 2'b11
    } op_e;

    // Widest intermediate the clamp helper can handle.
    localparam int SAT_MAX_W = 128;

    function automatic int calc_w(input int aw, input int bw, input int cw, input int pw);
        int m;
        m = aw + bw;
        if (cw > m) m = cw;
        if (pw > m) m = pw;
        return m + 2;
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          width
    );
        logic signed [SAT_MAX_W-1:0] one;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        one = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/mult_add_pipe_sat_round.sv
// Combinational clamp of a W-bit signed sum to P_WIDTH bits with a saturation flag.
module sat_round
    import mult_add_pipe_pkg::*;
#(
    parameter int W       = 34,
    parameter int P_WIDTH = 32
) (
    input  logic signed [W-1:0]       s,
    output logic        [P_WIDTH-1:0] p,
    output logic                      sat
);

    logic signed [SAT_MAX_W-1:0] s_ext;
    logic signed [SAT_MAX_W-1:0] clamped;

    always_comb begin
        s_ext   = {{(SAT_MAX_W-W){s[W-1]}}, s};
        clamped = sat_clamp(s_ext, P_WIDTH);
        p       = clamped[P_WIDTH-1:0];
        sat     = (clamped != s_ext);
    end

endmodule

// File: rtl/mult_add_pipe.sv
// Three-stage signed multiply-add/subtract with per-channel accumulators and output saturation.
module mult_add_pipe
    import mult_add_pipe_pkg::*;
#(
    parameter int A_WIDTH  = 16,
    parameter int B_WIDTH  = 16,
    parameter int C_WIDTH  = 32,
    parameter int P_WIDTH  = 32,
    parameter int CHANNELS = 4,
    parameter int CH_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [A_WIDTH-1:0]  a,
    input  logic signed [B_WIDTH-1:0]  b,
    input  logic signed [C_WIDTH-1:0]  c,
    input  logic        [CH_WIDTH-1:0] ch,
    input  logic                       subtract,
    input  logic                       accumulate,
    input  logic                       acc_clear,
    output logic                       out_valid,
    output logic        [P_WIDTH-1:0]  p,
    output logic                       sat,
    output logic        [CH_WIDTH-1:0] out_ch
);

    localparam int W       = calc_w(A_WIDTH, B_WIDTH, C_WIDTH, P_WIDTH);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH;

    logic                       s1_valid;
    logic signed [A_WIDTH-1:0]  s1_a;
    logic signed [B_WIDTH-1:0]  s1_b;
    logic signed [C_WIDTH-1:0]  s1_c;
    logic        [CH_WIDTH-1:0] s1_ch;
    op_e                        s1_op;

    logic                       s2_valid;
    logic signed [M_WIDTH-1:0]  s2_prod;
    logic signed [C_WIDTH-1:0]  s2_c;
    logic        [CH_WIDTH-1:0] s2_ch;
    op_e                        s2_op;

    logic [P_WIDTH-1:0] acc [CHANNELS];
    logic [P_WIDTH-1:0] acc_rd;
    logic signed [W-1:0] prod_w;
    logic signed [W-1:0] addend_w;
    logic signed [W-1:0] sum_w;
    logic [P_WIDTH-1:0] p_next;
    logic               sat_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_ch    <= '0;
            s1_op    <= ADD;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_c  <= c;
                s1_ch <= ch;
                s1_op <= op_e'({accumulate, subtract});
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_prod  <= '0;
            s2_c     <= '0;
            s2_ch    <= '0;
            s2_op    <= ADD;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_prod <= M_WIDTH'(s1_a) * M_WIDTH'(s1_b);
                s2_c    <= s1_c;
                s2_ch   <= s1_ch;
                s2_op   <= s1_op;
            end
        end
    end

    // Out-of-range channels match no bank entry, so they read as zero and are never written.
    always_comb begin
        acc_rd = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (s2_ch == CH_WIDTH'(i)) acc_rd = acc[i];
        end
    end

    always_comb begin
        prod_w   = W'(s2_prod);
        addend_w = (s2_op inside {ACC_ADD, ACC_SUB}) ? W'($signed(acc_rd)) : W'(s2_c);
        sum_w    = (s2_op inside {SUB, ACC_SUB}) ? addend_w - prod_w : addend_w + prod_w;
    end

    sat_round #(
        .W       (W),
        .P_WIDTH (P_WIDTH)
    ) u_sat_round (
        .s   (sum_w),
        .p   (p_next),
        .sat (sat_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            p         <= '0;
            sat       <= 1'b0;
            out_ch    <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                p      <= p_next;
                sat    <= sat_next;
                out_ch <= s2_ch;
            end
        end
    end

    // Clear takes priority over a same-edge write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else if (acc_clear) begin
            for (int unsigned i = 0; i < CHANNELS; i++) acc[i] <= '0;
        end else if (s2_valid) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (s2_ch == CH_WIDTH'(i)) acc[i] <= p_next;
            end
        end
    end

endmodule

// File: tb/tb_mult_add_pipe.sv
// Self-checking bench for mult_add_pipe: directed spec vectors plus randomized ops against a queue-based model.
module tb_mult_add_pipe;

    localparam int NCH = 3;
    localparam longint PMAX = 64'sd2147483647;
    localparam longint PMIN = -64'sd2147483648;

    typedef struct {
        bit          v;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        logic [1:0]  ch;
        bit          sub;
        bit          acc;
        bit          clr;
    } drv_t;

    typedef struct {
        bit          v;
        logic [31:0] p;
        bit          s;
        logic [1:0]  ch;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] c;
        int          ch;
        bit          sub;
        bit          acc;
    } op_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [31:0] c = '0;
    logic [1:0]  ch = '0;
    logic        subtract = 1'b0;
    logic        accumulate = 1'b0;
    logic        acc_clear = 1'b0;
    logic        out_valid;
    logic [31:0] p;
    logic        sat;
    logic [1:0]  out_ch;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;

    longint      macc [NCH];
    op_t         pq [$];
    logic [31:0] last_p = '0;
    bit          last_s = 1'b0;
    logic [1:0]  last_ch = '0;

    mult_add_pipe #(
        .A_WIDTH  (16),
        .B_WIDTH  (16),
        .C_WIDTH  (32),
        .P_WIDTH  (32),
        .CHANNELS (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .c          (c),
        .ch         (ch),
        .subtract   (subtract),
        .accumulate (accumulate),
        .acc_clear  (acc_clear),
        .out_valid  (out_valid),
        .p          (p),
        .sat        (sat),
        .out_ch     (out_ch)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        pq.delete();
        for (int i = 0; i < NCH; i++) macc[i] = 0;
        last_p  = '0;
        last_s  = 1'b0;
        last_ch = '0;
    endfunction

    // Plain integer arithmetic: X +/- a*b, then clamp to the signed 32-bit range.
    function automatic void model_exec(input op_t o);
        longint x, pr, s;
        pr = longint'($signed(o.a)) * longint'($signed(o.b));
        if (o.acc) x = (o.ch < NCH) ? macc[o.ch] : 0;
        else       x = longint'($signed(o.c));
        s = o.sub ? x - pr : x + pr;
        if (s > PMAX) begin
            last_p = 32'h7fffffff; last_s = 1'b1;
        end else if (s < PMIN) begin
            last_p = 32'h80000000; last_s = 1'b1;
        end else begin
            last_p = s[31:0]; last_s = 1'b0;
        end
        last_ch = o.ch[1:0];
        if (o.ch < NCH) macc[o.ch] = longint'($signed(last_p));
    endfunction

    task automatic step(input drv_t d, output exp_t e);
        op_t o;
        in_valid   = d.v;
        a          = d.a;
        b          = d.b;
        c          = d.c;
        ch         = d.ch;
        subtract   = d.sub;
        accumulate = d.acc;
        acc_clear  = d.clr;
        @(posedge clk);
        edge_n++;
        if (d.v) begin
            o.due = edge_n + 2; o.a = d.a; o.b = d.b; o.c = d.c;
            o.ch = int'(d.ch); o.sub = d.sub; o.acc = d.acc;
            pq.push_back(o);
        end
        e.v = 1'b0;
        if (pq.size() != 0 && pq[0].due == edge_n) begin
            o = pq.pop_front();
            model_exec(o);
            e.v = 1'b1;
        end
        if (d.clr) for (int i = 0; i < NCH; i++) macc[i] = 0;
        e.p = last_p; e.s = last_s; e.ch = last_ch;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %0b, expected 0", out_valid);
        end
        vectors++;
        if (p !== 32'h0) begin
            miscompares++; $display("FAIL reset_p: got %h, expected 00000000", p);
        end
        vectors++;
        if (sat !== 1'b0 || out_ch !== 2'd0) begin
            miscompares++; $display("FAIL reset_sat_ch: got sat=%0b ch=%0d, expected 0 0", sat, out_ch);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_arith();
        drv_t d [7];
        exp_t e [7];
        exp_t got;
        d = '{'{1, 16'h4fff, 16'h4fff, 32'h4fffffff, 2'd0, 0, 0, 0},
              '{1, 16'hfff0, 16'h4000, 32'h00000000, 2'd3, 0, 0, 0},
              '{1, 16'hfff0, 16'h4000, 32'h00000000, 2'd0, 1, 0, 0},
              '{1, 16'h7fff, 16'h7fff, 32'h7fffffff, 2'd3, 0, 0, 0},
              '{1, 16'h7fff, 16'h7fff, 32'h80000000, 2'd0, 1, 0, 0},
              '{0, 16'h0, 16'h0, 32'h0, 2'd0, 0, 0, 0},
              '{0, 16'h0, 16'h0, 32'h0, 2'd0, 0, 0, 0}};
        e = '{'{0, 32'h0, 0, 2'd0}, '{0, 32'h0, 0, 2'd0},
              '{1, 32'h68FF6000, 0, 2'd0}, '{1, 32'hFFFC0000, 0, 2'd3},
              '{1, 32'h00040000, 0, 2'd0}, '{1, 32'h7FFFFFFF, 1, 2'd3},
              '{1, 32'h80000000, 1, 2'd0}};
        for (int i = 0; i < 7; i++) begin
            step(d[i], got);
            vectors++;
            if (out_valid !== e[i].v || (e[i].v && (p !== e[i].p || sat !== e[i].s || out_ch !== e[i].ch))) begin
                miscompares++;
                $display("FAIL arith[%0d]: got v=%0b p=%h sat=%0b ch=%0d, expected v=%0b p=%h sat=%0b ch=%0d",
                         i, out_valid, p, sat, out_ch, e[i].v, e[i].p, e[i].s, e[i].ch);
            end
        end
    endtask

    task automatic test_accum_hazard();
        drv_t d [7];
        exp_t e [7];
        exp_t got;
        d = '{'{1, 16'd0, 16'd0, 32'd100, 2'd2, 0, 0, 0},
              '{1, 16'd2, 16'd3, 32'd0, 2'd2, 0, 1, 0},
              '{1, 16'd2, 16'd3, 32'd0, 2'd2, 0, 1, 0},
              '{1, 16'd2, 16'd3, 32'd0, 2'd2, 0, 1, 0},
              '{1, 16'd0, 16'd0, 32'd0, 2'd1, 0, 1, 0},
              '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 0},
              '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 0}};
        e = '{'{0, 32'd0, 0, 2'd0}, '{0, 32'd0, 0, 2'd0},
              '{1, 32'd100, 0, 2'd2}, '{1, 32'd106, 0, 2'd2},
              '{1, 32'd112, 0, 2'd2}, '{1, 32'd118, 0, 2'd2},
              '{1, 32'd0, 0, 2'd1}};
        for (int i = 0; i < 7; i++) begin
            step(d[i], got);
            vectors++;
            if (out_valid !== e[i].v || (e[i].v && (p !== e[i].p || sat !== e[i].s || out_ch !== e[i].ch))) begin
                miscompares++;
                $display("FAIL accum[%0d]: got v=%0b p=%h sat=%0b ch=%0d, expected v=%0b p=%h sat=%0b ch=%0d",
                         i, out_valid, p, sat, out_ch, e[i].v, e[i].p, e[i].s, e[i].ch);
            end
        end
    endtask

    // Clear lands on the same edge as the write-back of step 0's op.
    task automatic test_clear();
        drv_t d [7];
        exp_t e [7];
        exp_t got;
        d = '{'{1, 16'd1, 16'd5, 32'd0, 2'd2, 0, 1, 0},
              '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 0},
              '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 1},
              '{1, 16'd0, 16'd0, 32'd0, 2'd2, 0, 1, 0},
              '{1, 16'd0, 16'd0, 32'd0, 2'd0, 0, 1, 0},
              '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 0},
              '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 0}};
        e = '{'{0, 32'd0, 0, 2'd0}, '{0, 32'd0, 0, 2'd0},
              '{1, 32'd123, 0, 2'd2}, '{0, 32'd0, 0, 2'd0},
              '{0, 32'd0, 0, 2'd0}, '{1, 32'd0, 0, 2'd2},
              '{1, 32'd0, 0, 2'd0}};
        for (int i = 0; i < 7; i++) begin
            step(d[i], got);
            vectors++;
            if (out_valid !== e[i].v || (e[i].v && (p !== e[i].p || sat !== e[i].s || out_ch !== e[i].ch))) begin
                miscompares++;
                $display("FAIL clear[%0d]: got v=%0b p=%h sat=%0b ch=%0d, expected v=%0b p=%h sat=%0b ch=%0d",
                         i, out_valid, p, sat, out_ch, e[i].v, e[i].p, e[i].s, e[i].ch);
            end
        end
    endtask

    task automatic test_reset_midflight();
        drv_t d;
        exp_t got;
        d = '{1, 16'd1, 16'd1, 32'd5, 2'd0, 0, 0, 0};
        step(d, got);
        d = '{1, 16'd2, 16'd2, 32'd7, 2'd1, 0, 0, 0};
        step(d, got);
        in_valid = 1'b1; a = 16'd3; b = 16'd3; c = 32'd9; ch = 2'd2;
        #1 rst = 1'b1;
        @(posedge clk);
        edge_n++;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || p !== 32'h0 || sat !== 1'b0 || out_ch !== 2'd0) begin
            miscompares++;
            $display("FAIL midflight_reset: got v=%0b p=%h sat=%0b ch=%0d, expected 0 00000000 0 0", out_valid, p, sat, out_ch);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            d = '{0, 16'd0, 16'd0, 32'd0, 2'd0, 0, 0, 0};
            step(d, got);
            vectors++;
            if (out_valid !== 1'b0 || p !== 32'h0) begin
                miscompares++;
                $display("FAIL midflight_drain[%0d]: got v=%0b p=%h, expected 0 00000000", i, out_valid, p);
            end
        end
        for (int i = 0; i < NCH + 2; i++) begin
            d = '{(i < NCH), 16'd0, 16'd0, 32'd0, 2'(i), 0, 1, 0};
            step(d, got);
            if (i >= 2) begin
                vectors++;
                if (out_valid !== 1'b1 || p !== 32'h0 || out_ch !== 2'(i - 2)) begin
                    miscompares++;
                    $display("FAIL midflight_acc[%0d]: got v=%0b p=%h ch=%0d, expected 1 00000000 %0d", i - 2, out_valid, p, out_ch, i - 2);
                end
            end
        end
    endtask

    task automatic test_random();
        drv_t d;
        exp_t e;
        for (int i = 0; i < 302; i++) begin
            d.v   = (i < 300) && ($urandom_range(0, 3) != 0);
            d.a   = $urandom_range(0, 3) == 0 ? 16'h8000 : ($urandom_range(0, 3) == 0 ? 16'h7fff : 16'($urandom));
            d.b   = $urandom_range(0, 3) == 0 ? 16'h8000 : 16'($urandom);
            d.c   = $urandom_range(0, 3) == 0 ? 32'h7ffffff0 : $urandom;
            d.ch  = 2'($urandom_range(0, 3));
            d.sub = 1'($urandom_range(0, 1));
            d.acc = 1'($urandom_range(0, 1));
            d.clr = ($urandom_range(0, 15) == 0);
            step(d, e);
            vectors++;
            if (out_valid !== e.v || p !== e.p || sat !== e.s || out_ch !== e.ch) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%0b p=%h sat=%0b ch=%0d, expected v=%0b p=%h sat=%0b ch=%0d",
                         i, out_valid, p, sat, out_ch, e.v, e.p, e.s, e.ch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_accum_hazard();
        test_clear();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
